// File: rtl/uart_rx_if.sv
// Receive-side bus between the UART receiver and the CPU bus bridge.
// The receiver drives the byte/status signals; the consumer returns rx_ack.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (output rx_data, rx_valid, frame_err, overrun, busy, input rx_ack);
  modport slave  (input  rx_data, rx_valid, frame_err, overrun, busy, output rx_ack);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes RXD, rebuilds bytes LSB-first and hands them
// to the bus through a one-entry holding register with framing/overrun status.
module uart_rx #(
  parameter int CLK_FREQ_HZ = 10_000_000,
  parameter int BAUD_RATE   = 115200
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RXD,
  uart_rx_if.master  bus
);
  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  if (CLKS_PER_BIT < 4) begin : g_cfg_err
    $error("uart_rx: CLKS_PER_BIT must be at least 4");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  logic [1:0]    r_sync;
  state_t        r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [2:0]    r_idx, w_idx_n;
  logic [7:0]    r_sh, w_sh_n;
  logic [7:0]    r_data;
  logic          r_valid, r_ferr, r_ovr, r_busy;
  logic          w_rxd_s, w_load, w_ferr_n, w_ack, w_valid_n, w_ovr_n;

  assign w_rxd_s = r_sync[1];

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_idx_n   = r_idx;
    w_sh_n    = r_sh;
    w_load    = 1'b0;
    w_ferr_n  = 1'b0;
    case (r_state)
      S_IDLE: if (!w_rxd_s) begin
        w_state_n = S_START;
        w_cnt_n   = '0;
      end
      S_START: begin
        // Re-check the line half a bit in; a high level means the edge was a glitch.
        if (r_cnt == HALF_LAST) begin
          w_cnt_n = '0;
          if (!w_rxd_s) begin
            w_state_n = S_DATA;
            w_idx_n   = '0;
          end else begin
            w_state_n = S_IDLE;
          end
        end else begin
          w_cnt_n = r_cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_n = '0;
          w_sh_n  = {w_rxd_s, r_sh[7:1]};
          if (r_idx == 3'd7) w_state_n = S_STOP;
          else               w_idx_n   = r_idx + 3'd1;
        end else begin
          w_cnt_n = r_cnt + CW'(1);
        end
      end
      S_STOP: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_n = '0;
          if (w_rxd_s) begin
            w_load    = 1'b1;
            w_state_n = S_IDLE;
          end else begin
            w_ferr_n  = 1'b1;
            w_state_n = S_BREAK;
          end
        end else begin
          w_cnt_n = r_cnt + CW'(1);
        end
      end
      S_BREAK: if (w_rxd_s) w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  // A load that coincides with an ack replaces the byte without flagging overrun.
  assign w_ack     = bus.rx_ack & r_valid;
  assign w_valid_n = w_load | (r_valid & ~w_ack);
  assign w_ovr_n   = (w_load & r_valid & ~bus.rx_ack) | (r_ovr & ~w_ack);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sync  <= 2'b11;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_sh    <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], RXD};
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_idx   <= w_idx_n;
      r_sh    <= w_sh_n;
      if (w_load) r_data <= r_sh;
      r_valid <= w_valid_n;
      r_ferr  <= w_ferr_n;
      r_ovr   <= w_ovr_n;
      r_busy  <= (w_state_n != S_IDLE);
    end
  end

  assign bus.rx_data   = r_data;
  assign bus.rx_valid  = r_valid;
  assign bus.frame_err = r_ferr;
  assign bus.overrun   = r_ovr;
  assign bus.busy      = r_busy;
endmodule
